// File: rtl/pwm_capture.sv
// pwm_capture: recovers W-bit PCM samples from a PWM pin by timing the high phase of each 2^W-clock period.
// Optional `PWM_CAPTURE_GLITCH_FILTER_EN inserts a registered 3-tap majority filter ahead of the edge detector.
module pwm_capture #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pwm_in,
    output logic [W-1:0] sample,
    output logic         sample_vld,
    input  logic         sample_rdy,
    output logic         locked,
    output logic         err_phase,
    output logic         err_overrun,
    input  logic         clr_err
);

    localparam logic [1:0]   ST_SEARCH  = 2'd0;
    localparam logic [1:0]   ST_ACQUIRE = 2'd1;
    localparam logic [1:0]   ST_LOCKED  = 2'd2;
    localparam logic [W-1:0] PH_LAST    = {W{1'b1}};
    localparam logic [W:0]   HC_MAX     = {1'b0, {W{1'b1}}};
    localparam logic [W:0]   HC_ONE     = {{W{1'b0}}, 1'b1};

    function automatic logic [W-1:0] sat_sample(input logic [W:0] v);
        return (v > HC_MAX) ? {W{1'b1}} : v[W-1:0];
    endfunction

    logic [1:0]   sync_q;
    logic         p;
    logic         pf;
    logic         pf_prev_q;
    logic         rise;
    logic [1:0]   state_q, state_d;
    logic [W-1:0] ph_q, ph_d;
    logic [W:0]   hc_q, hc_d;
    logic [W:0]   hc_inc;
    logic [W-1:0] sample_q, sample_d;
    logic         vld_q, vld_d;
    logic         errp_q, errp_d;
    logic         erro_q, erro_d;
    logic         load;
    logic         phase_ev;
    logic         ovr_ev;

    assign p = sync_q[1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic p_d1_q, p_d2_q, filt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_d1_q <= 1'b0;
            p_d2_q <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            p_d1_q <= p;
            p_d2_q <= p_d1_q;
            filt_q <= maj3(p, p_d1_q, p_d2_q);
        end
    end

    assign pf = filt_q;
`else
    assign pf = p;
`endif

    assign rise   = pf & ~pf_prev_q;
    assign hc_inc = hc_q + {{W{1'b0}}, pf};

    // Phase tracking: lock only when an edge lands exactly where ph wraps to 0.
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        hc_d     = hc_q;
        load     = 1'b0;
        phase_ev = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                ph_d = '0;
                hc_d = '0;
                if (rise) begin
                    ph_d    = {{(W-1){1'b0}}, 1'b1};
                    hc_d    = HC_ONE;
                    state_d = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                ph_d = ph_q + 1'b1;
                if (rise) begin
                    hc_d = HC_ONE;
                    if (ph_q == '0) begin
                        state_d = ST_LOCKED;
                    end else begin
                        ph_d = {{(W-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_LOCKED: begin
                ph_d = ph_q + 1'b1;
                hc_d = hc_inc;
                if (rise && (ph_q != '0)) begin
                    phase_ev = 1'b1;
                    state_d  = ST_ACQUIRE;
                    ph_d     = {{(W-1){1'b0}}, 1'b1};
                    hc_d     = HC_ONE;
                end else if (ph_q == PH_LAST) begin
                    load = 1'b1;
                    hc_d = '0;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                ph_d    = '0;
                hc_d    = '0;
            end
        endcase
    end

    // Holding register: a load always wins over a same-cycle accept.
    always_comb begin
        sample_d = load ? sat_sample(hc_inc) : sample_q;
        ovr_ev   = load && vld_q && !sample_rdy;
        if (load) begin
            vld_d = 1'b1;
        end else if (vld_q && sample_rdy) begin
            vld_d = 1'b0;
        end else begin
            vld_d = vld_q;
        end
        errp_d = phase_ev | (errp_q & ~clr_err);
        erro_d = ovr_ev   | (erro_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '0;
            pf_prev_q <= 1'b0;
            state_q   <= ST_SEARCH;
            ph_q      <= '0;
            hc_q      <= '0;
            sample_q  <= '0;
            vld_q     <= 1'b0;
            errp_q    <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], pwm_in};
            pf_prev_q <= pf;
            state_q   <= state_d;
            ph_q      <= ph_d;
            hc_q      <= hc_d;
            sample_q  <= sample_d;
            vld_q     <= vld_d;
            errp_q    <= errp_d;
            erro_q    <= erro_d;
        end
    end

    assign sample      = sample_q;
    assign sample_vld  = vld_q;
    assign locked      = (state_q == ST_LOCKED);
    assign err_phase   = errp_q;
    assign err_overrun = erro_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Table-driven bench for pwm_capture: each row drives one PWM period and checks the outputs at its end.
module tb_pwm_capture;

    logic       clk;
    logic       rst_n;
    logic       pwm_in;
    logic [7:0] sample;
    logic       sample_vld;
    logic       sample_rdy;
    logic       locked;
    logic       err_phase;
    logic       err_overrun;
    logic       clr_err;

    pwm_capture #(.W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .sample     (sample),
        .sample_vld (sample_vld),
        .sample_rdy (sample_rdy),
        .locked     (locked),
        .err_phase  (err_phase),
        .err_overrun(err_overrun),
        .clr_err    (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         s;
        int         dly;
        int         glitch;
        logic       rdy;
        logic       clr;
        int         inc;
        logic [7:0] smp;
        logic       vld;
        logic       lk;
        logic       ep;
        logic       eo;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_acc = 0;
    logic [7:0] last_acc = 8'h00;

    // Record every sample the consumer actually takes.
    always @(negedge clk) begin
        if (sample_vld && sample_rdy) begin
            n_acc    <= n_acc + 1;
            last_acc <= sample;
        end
    end

    function automatic vec_t mk(input int s, input int dly, input int gl, input logic rdy,
                                input logic clr, input int inc, input logic [7:0] smp,
                                input logic vld, input logic lk, input logic ep, input logic eo);
        vec_t v;
        v.s = s; v.dly = dly; v.glitch = gl; v.rdy = rdy; v.clr = clr;
        v.inc = inc; v.smp = smp; v.vld = vld; v.lk = lk; v.ep = ep; v.eo = eo;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic lvl);
        pwm_in = lvl;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int i);
        vec_t v;
        int   base;
        v = vq[i];
        sample_rdy = v.rdy;
        base = n_acc;
        for (int k = 0; k < v.dly + 256; k++) begin
            clr_err = v.clr && (k == 0);
            tick((k >= v.dly) && ((k - v.dly) < v.s) && ((k - v.dly) != v.glitch));
        end
        clr_err = 1'b0;
        check($sformatf("row%0d accepted", i), n_acc - base, v.inc);
        if (v.inc > 0) check($sformatf("row%0d last_acc", i), last_acc, v.smp);
        check($sformatf("row%0d sample", i), sample, v.smp);
        check($sformatf("row%0d sample_vld", i), sample_vld, v.vld);
        check($sformatf("row%0d locked", i), locked, v.lk);
        check($sformatf("row%0d err_phase", i), err_phase, v.ep);
        check($sformatf("row%0d err_overrun", i), err_overrun, v.eo);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) apply(i);
    endtask

    initial begin
        int base;
        pwm_in     = 1'b0;
        sample_rdy = 1'b1;
        clr_err    = 1'b0;
        rst_n      = 1'b0;

        //                 s  dly gl  rdy  clr  inc smp    vld  lk   ep   eo
        vq.push_back(mk('h40, 0, -1, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)); // 0
        vq.push_back(mk('h40, 0, -1, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h40, 0, -1, 1'b1, 1'b0, 1, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h40, 0, -1, 1'b1, 1'b0, 1, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h80, 0, -1, 1'b1, 1'b0, 1, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h80, 0, -1, 1'b1, 1'b0, 1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0)); // 5
        vq.push_back(mk('h00, 0, -1, 1'b1, 1'b0, 1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h00, 0, -1, 1'b1, 1'b0, 1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h00, 0, -1, 1'b1, 1'b0, 1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h00, 0, -1, 1'b1, 1'b0, 1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('hFF, 0, -1, 1'b1, 1'b0, 1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0)); // 10
        vq.push_back(mk('hFF, 0, -1, 1'b1, 1'b0, 1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(256,  0, -1, 1'b1, 1'b0, 1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h80, 0, -1, 1'b1, 1'b0, 1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h20, 0, -1, 1'b1, 1'b0, 1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h20, 0, -1, 1'b1, 1'b0, 1, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0)); // 15
        vq.push_back(mk('h20, 5, -1, 1'b1, 1'b0, 1, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0));
        vq.push_back(mk('h20, 0, -1, 1'b1, 1'b0, 0, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0));
        vq.push_back(mk('h20, 0, -1, 1'b1, 1'b1, 1, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h10, 0, -1, 1'b1, 1'b0, 1, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h10, 0, -1, 1'b1, 1'b0, 1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0)); // 20
        vq.push_back(mk('h11, 0, -1, 1'b0, 1'b0, 0, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h11, 0, -1, 1'b0, 1'b0, 0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1));
        vq.push_back(mk('h11, 0, -1, 1'b1, 1'b1, 1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h40, 0, -1, 1'b1, 1'b0, 1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h40, 0, -1, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)); // 25
        vq.push_back(mk('h40, 0, -1, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h80, 0, -1, 1'b1, 1'b0, 1, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h80, 0, -1, 1'b1, 1'b0, 1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0));
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        vq.push_back(mk('h80, 0, 'h30, 1'b1, 1'b0, 1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h80, 0, -1,  1'b1, 1'b0, 1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0)); // 30
        vq.push_back(mk('h80, 0, -1,  1'b1, 1'b0, 1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk('h80, 0, -1,  1'b1, 1'b0, 1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0));
`else
        vq.push_back(mk('h80, 0, 'h30, 1'b1, 1'b0, 1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0));
        vq.push_back(mk('h80, 0, -1,  1'b1, 1'b0, 0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0)); // 30
        vq.push_back(mk('h80, 0, -1,  1'b1, 1'b0, 0, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0));
        vq.push_back(mk('h80, 0, -1,  1'b1, 1'b0, 1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0));
`endif

        repeat (3) tick(1'b0);
        check("reset sample", sample, 0);
        check("reset sample_vld", sample_vld, 0);
        check("reset locked", locked, 0);
        check("reset err_phase", err_phase, 0);
        check("reset err_overrun", err_overrun, 0);
        rst_n = 1'b1;

        run_rows(0, 22);

        // One-clock ready pulse drains the overrun-held sample.
        sample_rdy = 1'b0;
        base = n_acc;
        for (int k = 0; k < 256; k++) begin
            if (k == 100) sample_rdy = 1'b1;
            tick(k < 'h11);
            if (k == 100) begin
                sample_rdy = 1'b0;
                check("rdy pulse sample_vld", sample_vld, 0);
            end
        end
        check("rdy pulse accepted", n_acc - base, 1);
        check("rdy pulse last_acc", last_acc, 'h11);
        check("rdy pulse err_overrun sticky", err_overrun, 1);

        run_rows(23, 24);

        // Mid-period reset pulse.
        for (int k = 0; k < 256; k++) begin
            if (k == 100) rst_n = 1'b0;
            tick(k < 'h40);
            if (k == 99) begin
                check("pre-reset locked", locked, 1);
                check("pre-reset sample", sample, 'h40);
            end
            if (k == 100) begin
                rst_n = 1'b1;
                check("mid reset sample", sample, 0);
                check("mid reset sample_vld", sample_vld, 0);
                check("mid reset locked", locked, 0);
                check("mid reset err_phase", err_phase, 0);
                check("mid reset err_overrun", err_overrun, 0);
            end
        end

        run_rows(25, 32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
